// File: rtl/data_mem_responder_if.sv
// MEM-stage data bus between the pipeline (master) and the data RAM responder (slave).
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data RAM responder: valid/ready requests, WAIT_CYCLES wait states, B/H/W stores, sign/zero loads.
// Define DMEM_MISALIGN_CHK_EN to flag misaligned or reserved-funct3 accesses on rsp_err.
module data_mem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);
    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
    localparam bit         NO_WAIT  = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    typedef struct packed {
        logic              we;
        logic [2:0]        funct3;
        logic [ADDR_W+1:0] addr;
        logic [31:0]       wdata;
    } req_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    req_t        req_q, req_cur;
    logic [31:0] mem [DEPTH];

    logic              accept, commit, acc_err, mem_we;
    logic [ADDR_W-1:0] idx;
    logic [1:0]        lane;
    logic              is_byte, is_half, is_word;
    logic [31:0]       word, load_data, wword;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [3:0]        be;
    logic              rsp_valid_q;
    logic [31:0]       rsp_rdata_q;

    // Upper address bits alias onto the array by design.
    logic unused_addr;
    assign unused_addr = ^bus.req_addr[31:ADDR_W+2];

    assign bus.req_ready = (state == S_IDLE) && reset;
    assign accept        = bus.req_valid && bus.req_ready;
    // With no wait states the commit happens on the accept edge, straight from the bus.
    assign commit        = reset && ((accept && NO_WAIT) || (state == S_WAIT && cnt == 4'd0));

    always_comb begin
        req_cur = req_q;
        if (state == S_IDLE) begin
            req_cur.we     = bus.req_we;
            req_cur.funct3 = bus.req_funct3;
            req_cur.addr   = bus.req_addr[ADDR_W+1:0];
            req_cur.wdata  = bus.req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = NO_WAIT ? S_RESP : S_WAIT;
            S_WAIT:  if (cnt == 4'd0) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign idx     = req_cur.addr[ADDR_W+1:2];
    assign lane    = req_cur.addr[1:0];
    assign is_byte = (req_cur.funct3[1:0] == 2'b00);
    assign is_half = (req_cur.funct3[1:0] == 2'b01);
    assign is_word = !is_byte && !is_half;
    assign word    = mem[idx];
    assign byte_v  = word[{lane, 3'b000} +: 8];
    assign half_v  = lane[1] ? word[31:16] : word[15:0];

`ifdef DMEM_MISALIGN_CHK_EN
    assign acc_err = (is_half && lane[0]) || (is_word && lane != 2'b00) ||
                     (req_cur.funct3 inside {3'b011, 3'b110, 3'b111});
`else
    assign acc_err = 1'b0;
`endif

    always_comb begin
        load_data = word;
        wword     = req_cur.wdata;
        be        = 4'b1111;
        if (is_byte) begin
            load_data = {{24{byte_v[7] & ~req_cur.funct3[2]}}, byte_v};
            wword     = {4{req_cur.wdata[7:0]}};
            be        = 4'b0001 << lane;
        end else if (is_half) begin
            load_data = {{16{half_v[15] & ~req_cur.funct3[2]}}, half_v};
            wword     = {2{req_cur.wdata[15:0]}};
            be        = lane[1] ? 4'b1100 : 4'b0011;
        end
    end

    assign mem_we = commit && req_cur.we && !acc_err;

    // No reset on the array: contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
        end
    end

`ifdef DMEM_MISALIGN_CHK_EN
    logic err_q, rsp_err_q;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt         <= 4'd0;
            req_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
`ifdef DMEM_MISALIGN_CHK_EN
            err_q       <= 1'b0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= (state == S_RESP);
            if (accept) begin
                req_q <= req_cur;
                cnt   <= CNT_INIT;
            end else if (state == S_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) rsp_rdata_q <= (req_cur.we || acc_err) ? 32'd0 : load_data;
`ifdef DMEM_MISALIGN_CHK_EN
            if (commit) err_q <= acc_err;
            rsp_err_q <= (state == S_RESP) && err_q;
`endif
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
`ifdef DMEM_MISALIGN_CHK_EN
    assign bus.rsp_err   = rsp_err_q;
`else
    assign bus.rsp_err   = 1'b0;
`endif
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: byte-array reference model, random and directed traffic.
module tb_data_mem_responder;
    localparam int WAIT = 3;

    logic clk = 1'b0;
    logic reset;
    data_mem_responder_if bus ();

    data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(WAIT)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t       exp_q[$];
    int         chk  = 0;
    int         errs = 0;
    int         cyc  = 0;
    logic [7:0] ref_b [4096];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: little-endian byte array over the 4 KB aliased space.
    function automatic logic [31:0] model(input logic we, input logic [2:0] f3,
                                          input logic [31:0] a, input logic [31:0] wd,
                                          input bit upd);
        int ba = int'(a[11:0]);
        int hb = ba & ~1;
        int wb = ba & ~3;
        logic [31:0] v;
        if (we) begin
            if (upd) begin
                case (f3[1:0])
                    2'b00: ref_b[ba] = wd[7:0];
                    2'b01: begin ref_b[hb] = wd[7:0]; ref_b[hb+1] = wd[15:8]; end
                    default: for (int k = 0; k < 4; k++) ref_b[wb+k] = wd[8*k +: 8];
                endcase
            end
            return 32'd0;
        end
        case (f3[1:0])
            2'b00: begin
                v = {24'd0, ref_b[ba]};
                if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
            end
            2'b01: begin
                v = {16'd0, ref_b[hb+1], ref_b[hb]};
                if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
            end
            default: v = {ref_b[wb+3], ref_b[wb+2], ref_b[wb+1], ref_b[wb]};
        endcase
        return v;
    endfunction

    // Monitor: every response must match the oldest outstanding expectation, including timing.
    always @(negedge clk) begin
        if (bus.rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_rdata", bus.rsp_rdata, e.rdata);
                check("rsp_err", {31'd0, bus.rsp_err}, 32'd0);
                check("rsp_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input bit have_exp, input logic [31:0] exp_v,
                         input bit expect_rsp, output int acc);
        int budget;
        logic [31:0] rd;
        exp_t e;
        @(negedge clk);
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.req_valid  = 1'b1;
        budget = 0;
        while (bus.req_ready !== 1'b1 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (bus.req_ready !== 1'b1) begin
            check("accept_timeout", {31'd0, bus.req_ready}, 32'd1);
            bus.req_valid = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc + 1;
        rd  = model(we, f3, a, wd, expect_rsp);
        if (expect_rsp) begin
            e.rdata = have_exp ? exp_v : rd;
            e.cyc   = acc + WAIT + 1;
            exp_q.push_back(e);
        end
        @(posedge clk);
    endtask

    task automatic drain();
        int budget = 0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        while (exp_q.size() != 0 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", exp_q.size(), 32'd0);
            exp_q.delete();
        end
    endtask

    initial begin
        int acc, prev;
        reset          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("reset_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        check("reset_ready_low", {31'd0, bus.req_ready}, 32'd0);
        reset = 1'b1;
        #1 check("ready_after_reset", {31'd0, bus.req_ready}, 32'd1);

        // Directed word/byte/half cases with fixed expected values.
        issue(1, 3'b010, 32'h10, 32'hDEADBEEF, 1, 32'h0, 1, acc);
        issue(0, 3'b010, 32'h10, 32'h0, 1, 32'hDEADBEEF, 1, acc);
        issue(1, 3'b000, 32'h13, 32'h00000080, 1, 32'h0, 1, acc);
        issue(0, 3'b000, 32'h13, 32'h0, 1, 32'hFFFFFF80, 1, acc);
        issue(0, 3'b100, 32'h13, 32'h0, 1, 32'h00000080, 1, acc);
        issue(0, 3'b010, 32'h10, 32'h0, 1, 32'h80ADBEEF, 1, acc);
        issue(0, 3'b010, 32'h11, 32'h0, 1, 32'h80ADBEEF, 1, acc);
        issue(1, 3'b010, 32'h20, 32'h0, 1, 32'h0, 1, acc);
        issue(1, 3'b001, 32'h22, 32'h00008001, 1, 32'h0, 1, acc);
        issue(0, 3'b001, 32'h22, 32'h0, 1, 32'hFFFF8001, 1, acc);
        issue(0, 3'b101, 32'h22, 32'h0, 1, 32'h00008001, 1, acc);
        issue(0, 3'b010, 32'h20, 32'h0, 1, 32'h80010000, 1, acc);
        issue(1, 3'b010, 32'h1000, 32'hCAFEF00D, 1, 32'h0, 1, acc);
        issue(0, 3'b010, 32'h0000, 32'h0, 1, 32'hCAFEF00D, 1, acc);
        drain();

        // Reset during WAIT drops the pending store.
        issue(1, 3'b010, 32'h30, 32'hAAAAAAAA, 1, 32'h0, 1, acc);
        drain();
        issue(1, 3'b010, 32'h30, 32'h12345678, 0, 32'h0, 0, acc);
        @(negedge clk);
        bus.req_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("ready_after_midreset", {31'd0, bus.req_ready}, 32'd1);
        check("rdata_after_midreset", bus.rsp_rdata, 32'd0);
        repeat (WAIT + 3) @(negedge clk);
        issue(0, 3'b010, 32'h30, 32'h0, 1, 32'hAAAAAAAA, 1, acc);
        drain();

        // Valid held high: accepts spaced WAIT+2 apart.
        prev = -1;
        for (int i = 0; i < 4; i++) begin
            issue(0, 3'b010, 32'h10, 32'h0, 0, 32'h0, 1, acc);
            if (prev >= 0) check("accept_spacing", acc - prev, WAIT + 2);
            prev = acc;
        end
        drain();

        // Prefill the random window, then randomized traffic with gaps.
        for (int w = 0; w < 64; w++)
            issue(1, 3'b010, w * 4, $urandom, 0, 32'h0, 1, acc);
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = ($urandom & 32'hFFFF_F000) | $urandom_range(0, 255);
            issue(logic'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
                  0, 32'h0, 1, acc);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                bus.req_valid = 1'b0;
                repeat ($urandom_range(0, 4)) @(negedge clk);
            end
        end
        drain();
        repeat (WAIT + 3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", chk, errs);
        $finish;
    end
endmodule
